// File: rtl/serial2parallel_if.sv
// Handshake bundle for the bit-serial input, the buffered parallel output
// and the frame status counters of the deserializing receiver.
interface serial2parallel_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  serial_data;
    logic                  serial_valid;
    logic                  serial_ready_out;
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  parallel_valid;
    logic                  parallel_last;
    logic                  parallel_ready_in;
    logic                  frame_done;
    logic [15:0]           byte_count;
    logic [15:0]           frame_count;

    modport master (
        output serial_data, serial_valid, parallel_ready_in,
        input  serial_ready_out, parallel_data, parallel_valid, parallel_last,
               frame_done, byte_count, frame_count
    );

    modport slave (
        input  serial_data, serial_valid, parallel_ready_in,
        output serial_ready_out, parallel_data, parallel_valid, parallel_last,
               frame_done, byte_count, frame_count
    );
endinterface

// File: rtl/serial2parallel.sv
// Bit-serial to word deserializer with a 2-entry {data,last} output buffer
// and frame tagging / frame completion counters.
module serial2parallel #(
    parameter int DATA_WIDTH  = 8,
    parameter int MSB_FIRST   = 1,
    parameter int FRAME_BYTES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    serial2parallel_if.slave  bus
);
    localparam int              CW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic [15:0]     LAST_BYTE = 16'(FRAME_BYTES - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];
    logic [1:0]            last_q, last_d;
    logic [15:0]           byte_cnt_q, byte_cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  frame_done_q, frame_done_d;

    logic                  serial_ready;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  push_last;
    logic [DATA_WIDTH-1:0] shift_in;

    // Ready depends only on flops, so the sink's ready never reaches the source.
    assign serial_ready = (bit_cnt_q != LAST_BIT) || (occ_q != 2'd2);
    assign accept       = bus.serial_valid && serial_ready;
    assign push         = accept && (bit_cnt_q == LAST_BIT);
    assign pop          = (occ_q != 2'd0) && bus.parallel_ready_in;
    assign push_last    = (byte_cnt_q == LAST_BYTE);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        shift_in = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (MSB_FIRST != 0) begin
                shift_in[i] = (i == 0) ? bus.serial_data : shift_q[(i > 0) ? i - 1 : 0];
            end else begin
                shift_in[i] = (i == DATA_WIDTH - 1) ? bus.serial_data
                                                    : shift_q[(i < DATA_WIDTH - 1) ? i + 1 : i];
            end
        end
    end

    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        occ_d        = occ_q;
        data_d[0]    = data_q[0];
        data_d[1]    = data_q[1];
        last_d       = last_q;
        byte_cnt_d   = byte_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;

        if (accept) begin
            shift_d   = shift_in;
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
        end

        if (push) begin
            byte_cnt_d = push_last ? 16'd0 : byte_cnt_q + 16'd1;
        end

        if (pop && last_q[0]) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
        end

        // Entry 0 is the head; push+pop at occ==2 cannot happen (final bit is stalled).
        if (push && pop) begin
            data_d[0] = shift_in;
            last_d[0] = push_last;
        end else if (pop) begin
            data_d[0] = data_q[1];
            last_d[0] = last_q[1];
            occ_d     = occ_q - 2'd1;
        end else if (push) begin
            if (occ_q == 2'd0) begin
                data_d[0] = shift_in;
                last_d[0] = push_last;
            end else begin
                data_d[1] = shift_in;
                last_d[1] = push_last;
            end
            occ_d = occ_q + 2'd1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            occ_q        <= 2'd0;
            // NOTE: the buffer storage is reset too, because the head drives parallel_data and must read 0 after reset.
            data_q[0]    <= '0;
            data_q[1]    <= '0;
            last_q       <= 2'b00;
            byte_cnt_q   <= 16'd0;
            frame_cnt_q  <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            occ_q        <= occ_d;
            data_q[0]    <= data_d[0];
            data_q[1]    <= data_d[1];
            last_q       <= last_d;
            byte_cnt_q   <= byte_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.serial_ready_out = serial_ready;
    assign bus.parallel_valid   = (occ_q != 2'd0);
    assign bus.parallel_data    = data_q[0];
    assign bus.parallel_last    = last_q[0];
    assign bus.frame_done       = frame_done_q;
    assign bus.byte_count       = byte_cnt_q;
    assign bus.frame_count      = frame_cnt_q;
endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench: dut_a is MSB-first with 4-word frames, dut_b is LSB-first
// with 1-word frames; both see the same serial stimulus.
module tb_serial2parallel;
    logic clk = 1'b0;
    logic reset;
    logic sd;
    logic sv;
    logic rdy_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_a [$];
    logic       lst_a [$];
    logic [7:0] got_b [$];
    logic       lst_b [$];
    int         fd_a;
    int         fd_b;
    logic [7:0] held;

    always #5 clk = ~clk;

    serial2parallel_if #(.DATA_WIDTH(8)) ifa ();
    serial2parallel_if #(.DATA_WIDTH(8)) ifb ();

    assign ifa.serial_data       = sd;
    assign ifa.serial_valid      = sv;
    assign ifa.parallel_ready_in = rdy_in;
    assign ifb.serial_data       = sd;
    assign ifb.serial_valid      = sv;
    assign ifb.parallel_ready_in = rdy_in;

    serial2parallel #(.DATA_WIDTH(8), .MSB_FIRST(1), .FRAME_BYTES(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    serial2parallel #(.DATA_WIDTH(8), .MSB_FIRST(0), .FRAME_BYTES(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: snapshot handshakes before the edge, log pops and pulses after it.
    task automatic tick(output bit accepted);
        bit         pa, pb, la, lb;
        logic [7:0] da, db;
        pa = ifa.parallel_valid && rdy_in;
        pb = ifb.parallel_valid && rdy_in;
        da = ifa.parallel_data;
        db = ifb.parallel_data;
        la = ifa.parallel_last;
        lb = ifb.parallel_last;
        accepted = sv && ifa.serial_ready_out;
        @(posedge clk);
        #1;
        if (pa) begin got_a.push_back(da); lst_a.push_back(la); end
        if (pb) begin got_b.push_back(db); lst_b.push_back(lb); end
        if (ifa.frame_done) fd_a++;
        if (ifb.frame_done) fd_b++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic send_bit(input logic b, input bit gap);
        bit acc;
        int budget;
        sd = b;
        sv = 1'b1;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 100) begin
            tick(acc);
            budget++;
        end
        if (!acc) check("bit_accept_timeout", 32'd0, 32'd1);
        if (gap) begin
            sv = 1'b0;
            tick(acc);
        end
    endtask

    task automatic send_byte(input logic [7:0] val, input bit gap);
        for (int i = 7; i >= 0; i--) send_bit(val[i], gap);
    endtask

    task automatic do_reset();
        bit acc;
        sv = 1'b0;
        reset = 1'b1;
        tick(acc);
        reset = 1'b0;
        got_a.delete(); lst_a.delete();
        got_b.delete(); lst_b.delete();
        fd_a = 0;
        fd_b = 0;
    endtask

    initial begin
        bit acc;
        int budget;
        logic [7:0] exp3 [3];
        logic [7:0] w3;
        reset = 1'b1; sd = 1'b0; sv = 1'b0; rdy_in = 1'b0;
        fd_a = 0; fd_b = 0;
        idle(2);

        // Reset values
        check("rst_ready",       32'(ifa.serial_ready_out), 32'd1);
        check("rst_valid",       32'(ifa.parallel_valid),   32'd0);
        check("rst_data",        32'(ifa.parallel_data),    32'h00);
        check("rst_last",        32'(ifa.parallel_last),    32'd0);
        check("rst_frame_done",  32'(ifa.frame_done),       32'd0);
        check("rst_byte_count",  32'(ifa.byte_count),       32'd0);
        check("rst_frame_count", 32'(ifa.frame_count),      32'd0);
        do_reset();

        // Single word MSB first: valid for exactly one cycle after the 8th bit
        rdy_in = 1'b1;
        send_byte(8'hA5, 1'b0);
        sv = 1'b0;
        check("a5_valid",      32'(ifa.parallel_valid), 32'd1);
        check("a5_data",       32'(ifa.parallel_data),  32'hA5);
        check("a5_byte_count", 32'(ifa.byte_count),     32'd1);
        idle(1);
        check("a5_valid_drop", 32'(ifa.parallel_valid), 32'd0);
        check("a5_nwords",     32'(got_a.size()),       32'd1);
        check("a5_b_data",     32'(ifb.parallel_valid ? 8'hFF : got_b[0]), 32'hA5);

        // Bit ordering
        send_byte(8'h80, 1'b0);
        sv = 1'b0;
        check("order_msb_first", 32'(ifa.parallel_data), 32'h80);
        check("order_lsb_first", 32'(ifb.parallel_data), 32'h01);
        idle(2);

        // Backpressure: buffer fills, final bit of the third word stalls
        do_reset();
        rdy_in = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        w3 = 8'h03;
        for (int i = 7; i >= 1; i--) send_bit(w3[i], 1'b0);
        sd = w3[0];
        sv = 1'b1;
        check("bp_ready_low", 32'(ifa.serial_ready_out), 32'd0);
        check("bp_occ_full",  32'(dut_a.occ_q),          32'd2);
        held = ifa.parallel_data;
        idle(3);
        check("bp_still_stalled", 32'(ifa.serial_ready_out), 32'd0);
        check("bp_hold_data",     32'(ifa.parallel_data),    32'h01);
        check("bp_hold_vs_prev",  32'(ifa.parallel_data),    32'(held));
        rdy_in = 1'b1;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 20) begin
            tick(acc);
            budget++;
        end
        if (!acc) check("bp_release_timeout", 32'd0, 32'd1);
        sv = 1'b0;
        idle(4);
        exp3 = '{8'h01, 8'h02, 8'h03};
        check("bp_nwords", 32'(got_a.size()), 32'd3);
        for (int i = 0; i < 3; i++) check($sformatf("bp_word%0d", i), 32'(got_a[i]), 32'(exp3[i]));

        // Gapped input
        do_reset();
        rdy_in = 1'b1;
        for (int i = 7; i >= 1; i--) send_bit(w3 ^ w3 ? 1'b0 : 1'b0, 1'b0);
        do_reset();
        begin
            logic [7:0] g;
            g = 8'h3C;
            for (int i = 7; i >= 1; i--) send_bit(g[i], 1'b1);
            send_bit(g[0], 1'b0);
        end
        sv = 1'b0;
        check("gap_valid", 32'(ifa.parallel_valid), 32'd1);
        check("gap_data",  32'(ifa.parallel_data),  32'h3C);
        idle(3);
        check("gap_nwords", 32'(got_a.size()), 32'd1);

        // Frame boundary: 4-word frame on dut_a, 1-word frames on dut_b
        do_reset();
        rdy_in = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        sv = 1'b0;
        idle(4);
        check("frm_nwords", 32'(got_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("frm_last%0d", i), 32'(lst_a[i]), (i == 3) ? 32'd1 : 32'd0);
        check("frm_done_pulses", 32'(fd_a),            32'd1);
        check("frm_frame_count", 32'(ifa.frame_count), 32'd1);
        check("frm_byte_count",  32'(ifa.byte_count),  32'd0);
        check("frm1_done_pulses", 32'(fd_b),            32'd4);
        check("frm1_frame_count", 32'(ifb.frame_count), 32'd4);
        check("frm1_all_last",    32'(lst_b.size() == 4 && lst_b[0] && lst_b[1] && lst_b[2] && lst_b[3]), 32'd1);

        // Reset mid-word discards the partial word
        do_reset();
        rdy_in = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        sv = 1'b0;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        send_byte(8'h5A, 1'b0);
        sv = 1'b0;
        idle(3);
        check("mid_nwords",     32'(got_a.size()),    32'd1);
        check("mid_word",       32'(got_a[0]),        32'h5A);
        check("mid_byte_count", 32'(ifa.byte_count),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial2parallel.md
# serial2parallel

Deserializing receiver for the bit-serial stream carried by the `serial_data`/`serial_valid`/`serial_ready` handshake in the 200 MHz image-processing domain. It accepts one bit per handshake and assembles bytes, most significant bit first by default. It presents each pooled-image byte on a valid/ready parallel port through a 2-entry output buffer. It also tags frame boundaries, so downstream checkers and sinks can recover the pooled image stream.

## Interface
- `DATA_WIDTH`, default 8: bits per parallel word.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in bit `DATA_WIDTH-1`; 0 means it lands in bit 0.
- `FRAME_BYTES`, default 1024: words per frame. Legal range is 1..65536.
- `clk` input, 1 bit: the single clock; all logic is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `serial_data` input, 1 bit: serial bit, qualified by `serial_valid`.
- `serial_valid` input, 1 bit: the upstream transmitter has a bit available.
- `serial_ready_out` output, 1 bit: this block can accept a bit.
- `parallel_data` output, `DATA_WIDTH` bits: the assembled word at the head of the buffer.
- `parallel_valid` output, 1 bit: the buffer head is valid.
- `parallel_last` output, 1 bit: the head word is the last word of its frame.
- `parallel_ready_in` input, 1 bit: the downstream sink accepts the head word.
- `frame_done` output, 1 bit: one-cycle pulse when a last-tagged word is popped.
- `byte_count` output, 16 bits: number of words pushed so far in the current frame.
- `frame_count` output, 16 bits: number of frames fully popped; wraps modulo 2^16.

## Operation
- Bit accept: a bit is accepted when `serial_valid && serial_ready_out`.
- Shift register: each accepted bit enters a `DATA_WIDTH`-bit shift register.
  - `MSB_FIRST=1`: shift left and insert at the LSB.
  - `MSB_FIRST=0`: shift right and insert at the MSB.
- Bit counter: `bit_cnt` runs 0..`DATA_WIDTH-1`.
  - It increments on each accepted bit.
  - When the bit accepted at `bit_cnt==DATA_WIDTH-1` is accepted, the counter wraps to 0 and the completed word, including that final bit, is pushed into the buffer.
- Ready rule: `serial_ready_out = (bit_cnt != DATA_WIDTH-1) || (occ < 2)`.
  - It is decoded from registers only; there is no combinational path from `parallel_ready_in`.
  - The stream therefore stalls only on the final bit of a word, and only when the buffer is full.
- Buffer: 2 entries, each holding {data, last}, with occupancy `occ` of 0..2.
  - `parallel_valid = (occ != 0)`. The head entry drives `parallel_data` and `parallel_last`.
  - A pop happens when `parallel_valid && parallel_ready_in`.
- Push and pop in the same cycle:
  - With `occ==1`: occupancy stays 1 and the new word becomes the head.
  - With `occ==2`: no push is possible, because the ready rule has blocked the final bit.
- Frame tagging:
  - `byte_count` increments on every push.
  - The push made while `byte_count==FRAME_BYTES-1` is tagged last, and `byte_count` then wraps to 0.
- Frame completion: popping a last-tagged word pulses `frame_done` on the next cycle and increments `frame_count` on that same cycle.
- Reset (synchronous, takes priority over everything):
  - Clears the shift register, `bit_cnt`, `occ`, the buffer contents, `byte_count` and `frame_count`.
  - A partially assembled word is discarded.
  - Words held in the buffer are dropped.

## Timing
- Reset values:
  - `serial_ready_out=1`
  - `parallel_valid=0`, `parallel_data=0`, `parallel_last=0`
  - `frame_done=0`, `byte_count=0`, `frame_count=0`
- Latency: the final bit is accepted in cycle N; `parallel_valid` is high and the data is stable in cycle N+1.
- Throughput: one word per `DATA_WIDTH` accepted bits. With `parallel_ready_in` held at 1, the serial input never stalls.
- Hold rule: while `parallel_valid=1` and `parallel_ready_in=0`, `parallel_data` and `parallel_last` hold stable.
- `frame_done`: high for exactly one cycle per frame, in the cycle after the pop of the last-tagged word.
- Gaps: `serial_valid` low cycles are ignored, and `bit_cnt` holds.
- `FRAME_BYTES=1`: every word is tagged last.

## Test plan
- Single word, MSB first:
  - Stimulus: reset, `parallel_ready_in=1`, then bits 1,0,1,0,0,1,0,1 on consecutive cycles.
  - Required: `parallel_data=0xA5` with `parallel_valid` for exactly one cycle, beginning the cycle after the 8th bit; `byte_count=1`.
- Bit ordering:
  - Stimulus: bit sequence 1,0,0,0,0,0,0,0.
  - Required: `MSB_FIRST=1` gives 0x80; `MSB_FIRST=0` gives 0x01.
- Backpressure:
  - Stimulus: `parallel_ready_in=0`; stream 0x01, 0x02, 0x03.
  - Required: `serial_ready_out` drops while the 8th bit of 0x03 is pending, with `occ=2`.
  - Stimulus: raise `parallel_ready_in`.
  - Required: 0x01, 0x02, 0x03 are delivered in order with no loss or duplication.
- Gapped input:
  - Stimulus: 0x3C sent with `serial_valid` low on every other cycle.
  - Required: a single 0x3C word, 1 cycle after the final accepted bit.
- Frame boundary:
  - Stimulus: `FRAME_BYTES=4`, stream 4 words.
  - Required: `parallel_last=1` only on word 4; `frame_done` pulses once after its pop; `frame_count=1`; `byte_count=0`.
- Reset mid-word:
  - Stimulus: 5 bits, then a 1-cycle `reset`, then 0x5A.
  - Required: exactly one word, equal to 0x5A; no stale bits.
